// File: rtl/mac_operand_stage.sv
// Operand feeder for the MAC atom: buffers packets, picks three indexed fields, issues one op per cycle (idle -> identity bubble).
// Issue is one edge after acceptance; o__pkt_ready drops only when the buffer is full, with no bypass on a same-cycle pop.

module mac_operand_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty when the low bits match
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end
endmodule

module mac_operand_stage #(
    parameter int COUNT_WIDTH = 32,
    parameter int NUM_FIELDS  = 8,
    parameter int IDX_WIDTH   = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i__cfg_we,
    input  logic [2:0]                        i__cfg_addr,
    input  logic [COUNT_WIDTH-1:0]            i__cfg_data,
    input  logic                              i__pkt_valid,
    output logic                              o__pkt_ready,
    input  logic [NUM_FIELDS*COUNT_WIDTH-1:0] i__pkt_fields,
    output logic [COUNT_WIDTH-1:0]            o__constant,
    output logic [COUNT_WIDTH-1:0]            o__pkt_1,
    output logic [COUNT_WIDTH-1:0]            o__pkt_2,
    output logic [COUNT_WIDTH-1:0]            o__pkt_3,
    output logic                              o__sel1,
    output logic                              o__sel2,
    output logic                              o__sel3,
    output logic                              o__issue,
    output logic [COUNT_WIDTH-1:0]            o__issue_count,
    output logic                              o__cfg_err
);
    localparam int FW = NUM_FIELDS * COUNT_WIDTH;

    logic [COUNT_WIDTH-1:0] r_constant;
    logic [IDX_WIDTH-1:0]   r_idx1;
    logic [IDX_WIDTH-1:0]   r_idx2;
    logic [IDX_WIDTH-1:0]   r_idx3;
    logic [2:0]             r_sels;
    logic                   r_enable;

    logic [COUNT_WIDTH-1:0] r_out_constant;
    logic [COUNT_WIDTH-1:0] r_out_p1;
    logic [COUNT_WIDTH-1:0] r_out_p2;
    logic [COUNT_WIDTH-1:0] r_out_p3;
    logic [2:0]             r_out_sels;
    logic                   r_out_issue;
    logic [COUNT_WIDTH-1:0] r_issue_count;
    logic                   r_cfg_err;

    logic [FW-1:0]          w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_oor;

    function automatic logic [COUNT_WIDTH-1:0] f_pick(input logic [FW-1:0] v,
                                                      input logic [IDX_WIDTH-1:0] idx);
        f_pick = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (idx == IDX_WIDTH'(k)) f_pick = v[k*COUNT_WIDTH +: COUNT_WIDTH];
        end
    endfunction

    function automatic logic f_oor(input logic [IDX_WIDTH-1:0] idx);
        f_oor = (int'(idx) >= NUM_FIELDS);
    endfunction

    assign o__pkt_ready = !w_full;
    assign w_push       = i__pkt_valid && !w_full;
    assign w_pop        = r_enable && !w_empty;
    assign w_oor        = f_oor(r_idx1) || f_oor(r_idx2) || f_oor(r_idx3);

    mac_operand_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (i__pkt_fields),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_constant <= COUNT_WIDTH'(1);
            r_idx1     <= IDX_WIDTH'(0);
            r_idx2     <= IDX_WIDTH'(1);
            r_idx3     <= IDX_WIDTH'(2);
            r_sels     <= 3'b000;
            r_enable   <= 1'b0;
        end else if (i__cfg_we) begin
            case (i__cfg_addr)
                3'd0:    r_constant <= i__cfg_data;
                3'd1:    r_idx1     <= i__cfg_data[IDX_WIDTH-1:0];
                3'd2:    r_idx2     <= i__cfg_data[IDX_WIDTH-1:0];
                3'd3:    r_idx3     <= i__cfg_data[IDX_WIDTH-1:0];
                3'd4:    r_sels     <= i__cfg_data[2:0];
                3'd5:    r_enable   <= i__cfg_data[0];
                default: ;
            endcase
        end
    end

    // Bubble operands (const 1, packets 0, sels 0) make the atom compute reg*1+0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_constant <= COUNT_WIDTH'(1);
            r_out_p1       <= '0;
            r_out_p2       <= '0;
            r_out_p3       <= '0;
            r_out_sels     <= 3'b000;
            r_out_issue    <= 1'b0;
            r_issue_count  <= '0;
            r_cfg_err      <= 1'b0;
        end else if (w_pop) begin
            r_out_constant <= r_constant;
            r_out_p1       <= f_pick(w_head, r_idx1);
            r_out_p2       <= f_pick(w_head, r_idx2);
            r_out_p3       <= f_pick(w_head, r_idx3);
            r_out_sels     <= r_sels;
            r_out_issue    <= 1'b1;
            r_issue_count  <= r_issue_count + COUNT_WIDTH'(1);
            r_cfg_err      <= r_cfg_err || w_oor;
        end else begin
            r_out_constant <= COUNT_WIDTH'(1);
            r_out_p1       <= '0;
            r_out_p2       <= '0;
            r_out_p3       <= '0;
            r_out_sels     <= 3'b000;
            r_out_issue    <= 1'b0;
        end
    end

    assign o__constant    = r_out_constant;
    assign o__pkt_1       = r_out_p1;
    assign o__pkt_2       = r_out_p2;
    assign o__pkt_3       = r_out_p3;
    assign o__sel1        = r_out_sels[0];
    assign o__sel2        = r_out_sels[1];
    assign o__sel3        = r_out_sels[2];
    assign o__issue       = r_out_issue;
    assign o__issue_count = r_issue_count;
    assign o__cfg_err     = r_cfg_err;
endmodule

// File: tb/tb_mac_operand_stage.sv
// Scoreboard bench for mac_operand_stage with six fields so index 6/7 is out of range.
module tb_mac_operand_stage;
    localparam int CW    = 32;
    localparam int NF    = 6;
    localparam int IW    = 3;
    localparam int DEPTH = 4;
    localparam int FW    = NF * CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [FW-1:0] pkt_fields;
    logic [CW-1:0] o_const, o_p1, o_p2, o_p3, o_count;
    logic          o_s1, o_s2, o_s3, o_issue, o_err;

    always #5 clk = ~clk;

    mac_operand_stage #(
        .COUNT_WIDTH (CW),
        .NUM_FIELDS  (NF),
        .IDX_WIDTH   (IW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i__cfg_we      (cfg_we),
        .i__cfg_addr    (cfg_addr),
        .i__cfg_data    (cfg_data),
        .i__pkt_valid   (pkt_valid),
        .o__pkt_ready   (pkt_ready),
        .i__pkt_fields  (pkt_fields),
        .o__constant    (o_const),
        .o__pkt_1       (o_p1),
        .o__pkt_2       (o_p2),
        .o__pkt_3       (o_p3),
        .o__sel1        (o_s1),
        .o__sel2        (o_s2),
        .o__sel3        (o_s3),
        .o__issue       (o_issue),
        .o__issue_count (o_count),
        .o__cfg_err     (o_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_on = 1'b0;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: packet queue plus config shadow, updated on every rising edge
    logic [FW-1:0] mq[$];
    logic [CW-1:0] m_const;
    logic [IW-1:0] m_idx1, m_idx2, m_idx3;
    logic [2:0]    m_sels;
    logic          m_en;
    logic [CW-1:0] e_const, e_p1, e_p2, e_p3, e_count;
    logic [2:0]    e_sels;
    logic          e_issue, e_err;

    function automatic logic [CW-1:0] pick(input logic [FW-1:0] v, input logic [IW-1:0] idx);
        int i;
        i = int'(idx);
        if (i >= NF) return '0;
        return v[i*CW +: CW];
    endfunction

    task automatic bubble();
        e_const = 32'd1; e_p1 = '0; e_p2 = '0; e_p3 = '0; e_sels = 3'b000; e_issue = 1'b0;
    endtask

    initial forever begin
        logic          rdy;
        logic [FW-1:0] h;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_const = 32'd1; m_idx1 = 3'd0; m_idx2 = 3'd1; m_idx3 = 3'd2;
            m_sels = 3'b000; m_en = 1'b0;
            bubble();
            e_count = '0; e_err = 1'b0;
        end else begin
            rdy = (mq.size() < DEPTH);
            if (m_en && mq.size() > 0) begin
                h = mq.pop_front();
                e_p1 = pick(h, m_idx1); e_p2 = pick(h, m_idx2); e_p3 = pick(h, m_idx3);
                e_const = m_const; e_sels = m_sels; e_issue = 1'b1;
                e_count = e_count + 32'd1;
                if (int'(m_idx1) >= NF || int'(m_idx2) >= NF || int'(m_idx3) >= NF) e_err = 1'b1;
            end else begin
                bubble();
            end
            if (pkt_valid && rdy) mq.push_back(pkt_fields);
            if (cfg_we) begin
                case (cfg_addr)
                    3'd0: m_const = cfg_data;
                    3'd1: m_idx1  = cfg_data[IW-1:0];
                    3'd2: m_idx2  = cfg_data[IW-1:0];
                    3'd3: m_idx3  = cfg_data[IW-1:0];
                    3'd4: m_sels  = cfg_data[2:0];
                    3'd5: m_en    = cfg_data[0];
                    default: ;
                endcase
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            chk("issue",    CW'(o_issue), CW'(e_issue));
            chk("constant", o_const, e_const);
            chk("pkt_1",    o_p1, e_p1);
            chk("pkt_2",    o_p2, e_p2);
            chk("pkt_3",    o_p3, e_p3);
            chk("sels",     CW'({o_s3, o_s2, o_s1}), CW'(e_sels));
            chk("count",    o_count, e_count);
            chk("cfg_err",  CW'(o_err), CW'(e_err));
            chk("ready",    CW'(pkt_ready), CW'(mq.size() < DEPTH));
        end
    end

    task automatic step(input logic v, input logic [FW-1:0] f, input logic we,
                        input logic [2:0] a, input logic [CW-1:0] d);
        pkt_valid = v; pkt_fields = f; cfg_we = we; cfg_addr = a; cfg_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 3'd0, '0);
    endtask

    task automatic cfg(input logic [2:0] a, input logic [CW-1:0] d);
        step(1'b0, '0, 1'b1, a, d);
    endtask

    task automatic push(input logic [FW-1:0] f);
        step(1'b1, f, 1'b0, 3'd0, '0);
    endtask

    function automatic logic [FW-1:0] mk(input logic [CW-1:0] base);
        logic [FW-1:0] f;
        for (int k = 0; k < NF; k++) f[k*CW +: CW] = base + CW'(10 * k);
        return f;
    endfunction

    initial begin
        logic [FW-1:0] rf;
        rst = 1'b1;
        pkt_valid = 1'b0; pkt_fields = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);

        // Basic issue: constant 5, sel2, default indices
        cfg(3'd0, 32'd5);
        cfg(3'd4, 32'b010);
        cfg(3'd5, 32'd1);
        push(mk(32'd10));
        idle(2);

        // Fill while disabled; fifth push must be refused, then drain in order
        cfg(3'd5, 32'd0);
        for (int i = 0; i < 5; i++) push(mk(CW'(100 * (i + 1))));
        idle(2);
        cfg(3'd5, 32'd1);
        idle(6);

        // Back-to-back streaming with simultaneous push and pop
        for (int i = 0; i < 6; i++) push(mk(CW'(1000 + 100 * i)));
        idle(10);

        // Index write on the same edge the head issues; upper data bits ignored
        push(mk(32'd5000));
        step(1'b1, mk(32'd6000), 1'b1, 3'd1, 32'hFFFF_FFF5);
        idle(2);
        cfg(3'd6, 32'd0);
        cfg(3'd7, 32'hFFFF_FFFF);

        // Out-of-range index yields zero and sets the sticky error
        cfg(3'd3, 32'd7);
        push(mk(32'd7000));
        idle(2);
        cfg(3'd3, 32'd2);
        push(mk(32'd7100));
        idle(3);

        // Reset with packets buffered: nothing stale issues afterwards
        cfg(3'd5, 32'd0);
        for (int i = 0; i < 3; i++) push(mk(CW'(8000 + 100 * i)));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
        cfg(3'd5, 32'd1);
        idle(3);
        push(mk(32'd9000));
        idle(2);

        // Random traffic with occasional config writes
        cfg(3'd5, 32'd1);
        for (int i = 0; i < 80; i++) begin
            for (int k = 0; k < NF; k++) rf[k*CW +: CW] = $urandom;
            if (i == 40) rst = 1'b1;
            step(1'($urandom_range(0, 1)), rf, ($urandom_range(0, 5) == 0),
                 3'($urandom_range(0, 7)), $urandom);
            rst = 1'b0;
        end
        cfg(3'd5, 32'd1);
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
